friscv_uc: RTL and testbench
============================

# friscv_uc

Control unit for the Frisc-V juice dispenser. Sequences the datapath: arms the HC-SR04 interface, confirms that a cup is present over several consecutive measurements, then runs the selected pump for a fixed number of one-second periods. It consumes the datapath status pulses (`fim_medida`, `fim_bomba`, `copo_posicionado`, button edges) and drives its control inputs (`medir`, `conta_bomba`, `zera_bomba`).

## Interface

**Parameters**
- `INTERVALO`, default 5_000_000: idle cycles between measurements (100 ms at 50 MHz).
- `TIMEOUT`, default 2_500_000: cycles to wait for `fim_medida` before re-measuring.
- `CONFIRMA`, default 2: consecutive positive measurements required (1..7).
- `DOSE`, default 3: pump duration, counted in `fim_bomba` pulses (1..15).

**Ports**
- `clock` in 1: system clock, 50 MHz.
- `reset` in 1: asynchronous, active-low (0 = reset).
- `liga_frisc_edge` in 1: one-cycle pulse; toggles the machine on/off.
- `liga_suco_1_edge` in 1: one-cycle pulse; selects juice 1.
- `liga_suco_2_edge` in 1: one-cycle pulse; selects juice 2.
- `fim_medida` in 1: one-cycle pulse; measurement done.
- `copo_posicionado` in 1: level; valid when `fim_medida` pulses.
- `fim_bomba` in 1: one-cycle pulse per elapsed second while `conta_bomba` is high.
- `medir` out 1: one-cycle pulse that starts a measurement.
- `conta_bomba` out 1: enables the second counter.
- `zera_bomba` out 1: clears the second counter (feeds an async clear). Must come straight from a flop.
- `bomba_1`, `bomba_2` out 1: pump drives.
- `ligado` out 1: machine on.
- `pronto` out 1: one-cycle pulse when a dose completes.
- `db_estado` out 4: current state code.

## Operation

**States (code)**
- `INICIAL` (0): off.
  - `liga_frisc_edge` → `AGUARDA_SUCO`.
- `AGUARDA_SUCO` (1): on, waiting for a selection.
  - A suco edge latches the selection (`suco_sel`), clears the confirm count → `MEDE`.
  - If both suco edges arrive together, juice 1 wins.
- `MEDE` (2): `medir`=1 for one cycle. Clears the cycle counter → `ESPERA_MEDIDA`.
- `ESPERA_MEDIDA` (3): waits for `fim_medida`.
  - `fim_medida` → `AVALIA`.
  - Cycle counter reaches `TIMEOUT`-1 → `MEDE`. A timeout does not change the confirm count.
  - If `fim_medida` and the timeout occur in the same cycle, `fim_medida` wins.
- `AVALIA` (4): uses `copo_posicionado` as sampled on the `fim_medida` cycle (registered).
  - Positive: confirm+1. If the new count equals `CONFIRMA` → `PREPARA`, else → `INTERVALO`.
  - Negative: confirm count cleared → `INTERVALO`.
- `INTERVALO` (5): waits `INTERVALO` cycles → `MEDE`.
- `PREPARA` (6): `zera_bomba`=1, seconds count cleared → `BOMBEIA`.
- `BOMBEIA` (7): `conta_bomba`=1, `zera_bomba`=0, and `bomba_1` or `bomba_2` high per `suco_sel`.
  - Each `fim_bomba` increments the seconds count.
  - `fim_bomba` while count = `DOSE`-1 → `FIM`.
- `FIM` (8): `pronto`=1, `zera_bomba`=1 → `AGUARDA_SUCO`.

**Global rules**
- `liga_frisc_edge` in any state other than `INICIAL` → `INICIAL`, overriding every other transition. This includes `BOMBEIA`; the pump stops next cycle.
- Suco edges outside `AGUARDA_SUCO` are ignored.
- `zera_bomba`=1 in every state except `BOMBEIA`.
- Unused state codes (9–15) → `INICIAL`.
- `ligado`=1 in every state except `INICIAL`.

**Counter widths**
- Cycle counter: 27 bits, shared by `TIMEOUT` and `INTERVALO`.
- Confirm count: 3 bits.
- Seconds count: 4 bits.
- No counter wraps: each is cleared on entry to the state that uses it.

## Timing

**Reset values** (while `reset`=0):
- State `INICIAL`, all counters 0, `suco_sel`=0.
- `medir`=0, `conta_bomba`=0, `zera_bomba`=1, `bomba_1`=0, `bomba_2`=0, `ligado`=0, `pronto`=0, `db_estado`=0.
- Reset mid-dose drops the pumps immediately (asynchronously).

**Output timing**
- Moore outputs are registered from the state; each changes the cycle after the triggering input.
- Event at cycle k:
  - `liga_frisc_edge` in `INICIAL` → `ligado`=1 at k+1.
  - Suco edge → `medir`=1 at k+1 only.
  - `fim_medida` → `AVALIA` at k+1, next state at k+2.
- Measurement re-issue delays:
  - After a timeout: `medir` re-pulses exactly `TIMEOUT`+1 cycles after the previous `medir`.
  - After a negative or non-final positive: `AVALIA` → `INTERVALO` → `medir` after `INTERVALO` cycles in `INTERVALO`.
- Dose:
  - `PREPARA` lasts one cycle; the pumps rise on the cycle after it.
  - The pump stays high until the `DOSE`-th `fim_bomba`, and falls on the next cycle, together with `pronto`=1.

## Test plan

Run with `INTERVALO`=8, `TIMEOUT`=20, `CONFIRMA`=2, `DOSE`=3, and `fim_bomba` emulated every 10 cycles while `conta_bomba` is high.

1. Reset low then high → all outputs at reset values; `liga_frisc_edge` → `ligado`=1, `db_estado`=1.
2. `liga_suco_2_edge`, then two `fim_medida` with copo=1 → `medir` pulses twice, 8-cycle gap in `INTERVALO` between them. Then `bomba_2`=1 for 3 `fim_bomba` pulses, `pronto` pulse, `db_estado` back to 1.
3. Copo pattern 1, 0, 1, 1 → no pump until the 4th measurement, since the 0 clears the count.
4. No `fim_medida` → `medir` re-pulses every 21 cycles; the confirm count is preserved.
5. `liga_frisc_edge` during `BOMBEIA` → `bomba_x`=0 and `zera_bomba`=1 next cycle, `db_estado`=0.
6. `liga_suco_1_edge` and `liga_suco_2_edge` in the same cycle → a full dose runs with `bomba_1` only. A suco edge injected during `BOMBEIA` is ignored.

Source files
------------

// File: rtl/friscv_uc.sv
// friscv_uc: control unit for the Frisc-V juice dispenser; confirms a cup over
// several measurements, then runs the selected pump for a fixed number of seconds.
module friscv_uc #(
    parameter int INTERVALO = 5_000_000,
    parameter int TIMEOUT   = 2_500_000,
    parameter int CONFIRMA  = 2,
    parameter int DOSE      = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       liga_frisc_edge,
    input  logic       liga_suco_1_edge,
    input  logic       liga_suco_2_edge,
    input  logic       fim_medida,
    input  logic       copo_posicionado,
    input  logic       fim_bomba,
    output logic       medir,
    output logic       conta_bomba,
    output logic       zera_bomba,
    output logic       bomba_1,
    output logic       bomba_2,
    output logic       ligado,
    output logic       pronto,
    output logic [3:0] db_estado
);
    localparam logic [3:0] S_INICIAL       = 4'd0;
    localparam logic [3:0] S_AGUARDA_SUCO  = 4'd1;
    localparam logic [3:0] S_MEDE          = 4'd2;
    localparam logic [3:0] S_ESPERA_MEDIDA = 4'd3;
    localparam logic [3:0] S_AVALIA        = 4'd4;
    localparam logic [3:0] S_INTERVALO     = 4'd5;
    localparam logic [3:0] S_PREPARA       = 4'd6;
    localparam logic [3:0] S_BOMBEIA       = 4'd7;
    localparam logic [3:0] S_FIM           = 4'd8;
    localparam logic [26:0] T_FIM = 27'(TIMEOUT - 1);
    localparam logic [26:0] I_FIM = 27'(INTERVALO - 1);
    localparam logic [2:0]  C_FIM = 3'(CONFIRMA);
    localparam logic [3:0]  D_FIM = 4'(DOSE - 1);

    logic [3:0]  estado, prox;
    logic [26:0] ciclos;
    logic [2:0]  conf;
    logic [3:0]  segs;
    logic        suco_sel, copo_reg, suco_edge;

    assign suco_edge = liga_suco_1_edge | liga_suco_2_edge;
    assign db_estado = estado;

    always_comb begin
        prox = S_INICIAL;
        case (estado)
            S_INICIAL:       prox = liga_frisc_edge ? S_AGUARDA_SUCO : S_INICIAL;
            S_AGUARDA_SUCO:  prox = suco_edge ? S_MEDE : S_AGUARDA_SUCO;
            S_MEDE:          prox = S_ESPERA_MEDIDA;
            S_ESPERA_MEDIDA: prox = fim_medida ? S_AVALIA : (ciclos == T_FIM) ? S_MEDE : S_ESPERA_MEDIDA;
            S_AVALIA:        prox = (copo_reg && (conf + 3'd1) == C_FIM) ? S_PREPARA : S_INTERVALO;
            S_INTERVALO:     prox = (ciclos == I_FIM) ? S_MEDE : S_INTERVALO;
            S_PREPARA:       prox = S_BOMBEIA;
            S_BOMBEIA:       prox = (fim_bomba && segs == D_FIM) ? S_FIM : S_BOMBEIA;
            S_FIM:           prox = S_AGUARDA_SUCO;
            default:         prox = S_INICIAL;
        endcase
        if (liga_frisc_edge && estado != S_INICIAL)
            prox = S_INICIAL;
    end

    // Outputs are decoded from the next state so every one of them is a flop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado      <= S_INICIAL;
            ciclos      <= '0;
            conf        <= '0;
            segs        <= '0;
            suco_sel    <= 1'b0;
            copo_reg    <= 1'b0;
            medir       <= 1'b0;
            conta_bomba <= 1'b0;
            zera_bomba  <= 1'b1;
            bomba_1     <= 1'b0;
            bomba_2     <= 1'b0;
            ligado      <= 1'b0;
            pronto      <= 1'b0;
        end else begin
            estado <= prox;
            ciclos <= (estado == S_ESPERA_MEDIDA || estado == S_INTERVALO) ? ciclos + 27'd1 : '0;
            segs   <= (estado == S_BOMBEIA) ? segs + {3'b000, fim_bomba} : '0;
            if (estado == S_AGUARDA_SUCO && suco_edge) begin
                conf     <= '0;
                suco_sel <= ~liga_suco_1_edge;
            end else if (estado == S_AVALIA)
                conf <= copo_reg ? conf + 3'd1 : '0;
            if (estado == S_ESPERA_MEDIDA && fim_medida)
                copo_reg <= copo_posicionado;
            medir       <= prox == S_MEDE;
            conta_bomba <= prox == S_BOMBEIA;
            zera_bomba  <= prox != S_BOMBEIA;
            bomba_1     <= prox == S_BOMBEIA && !suco_sel;
            bomba_2     <= prox == S_BOMBEIA && suco_sel;
            ligado      <= prox != S_INICIAL;
            pronto      <= prox == S_FIM;
        end
    end
endmodule

// File: tb/tb_friscv_uc.sv
// tb_friscv_uc: randomized bench for friscv_uc; the bench plays the datapath and
// predicts every output cycle from measurement outcomes and dose timing.
module tb_friscv_uc;
    localparam int TO = 20, IV = 8, CF = 2, DS = 3;

    logic clock = 0, reset = 1;
    logic liga = 0, s1 = 0, s2 = 0, fim_medida = 0, copo = 0, fim_bomba = 0;
    logic medir, conta_bomba, zera_bomba, bomba_1, bomba_2, ligado, pronto;
    logic [3:0] db_estado;
    int n_chk = 0, n_pass = 0, sel = 1;
    int pat[$];

    friscv_uc #(.INTERVALO(IV), .TIMEOUT(TO), .CONFIRMA(CF), .DOSE(DS)) dut (
        .clock(clock), .reset(reset), .liga_frisc_edge(liga),
        .liga_suco_1_edge(s1), .liga_suco_2_edge(s2), .fim_medida(fim_medida),
        .copo_posicionado(copo), .fim_bomba(fim_bomba), .medir(medir),
        .conta_bomba(conta_bomba), .zera_bomba(zera_bomba), .bomba_1(bomba_1),
        .bomba_2(bomba_2), .ligado(ligado), .pronto(pronto), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    endtask

    // {db_estado, medir, conta, zera, bomba_1, bomba_2, ligado, pronto} for a state code
    function automatic logic [10:0] exp_out(input int st, input int s);
        return {4'(st), st == 2, st == 7, st != 7, st == 7 && s == 1, st == 7 && s == 2, st != 0, st == 8};
    endfunction

    task automatic expect_st(input string tag, input int st);
        check(tag, {db_estado, medir, conta_bomba, zera_bomba, bomba_1, bomba_2, ligado, pronto}, exp_out(st, sel));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        liga = 0; s1 = 0; s2 = 0; fim_medida = 0; fim_bomba = 0;
    endtask

    task automatic noise();
        s1 = ($urandom_range(0, 7) == 0);
        s2 = ($urandom_range(0, 7) == 0);
    endtask

    // One selection from AGUARDA_SUCO; abort_at = pump cycle to interrupt (-1: none),
    // by_reset selects a reset pulse instead of liga_frisc_edge as the interruption.
    task automatic run_dose(input bit j1, input bit j2, input int abort_at, input bit by_reset);
        int conf = 0, guard = 0, o, d;
        expect_st("idle", 1);
        s1 = j1; s2 = j2; sel = j1 ? 1 : 2;
        tick; expect_st("select", 2);
        while (1) begin
            o = pat.size() > 0 ? pat.pop_front() : (($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 3) != 0));
            guard++;
            if (guard > 60) o = 1;
            if (o < 0) begin
                for (int i = 1; i <= TO; i++) begin noise(); tick; expect_st("wait_to", 3); end
                tick; expect_st("timeout_medir", 2);
                continue;
            end
            d = $urandom_range(1, TO);
            for (int i = 1; i <= d; i++) begin noise(); tick; expect_st("wait", 3); end
            fim_medida = 1; copo = o[0];
            tick; copo = 1'($urandom_range(0, 1)); expect_st("avalia", 4);
            conf = o[0] ? conf + 1 : 0;
            if (conf == CF) break;
            for (int i = 1; i <= IV; i++) begin noise(); tick; expect_st("intervalo", 5); end
            tick; expect_st("remeasure", 2);
        end
        tick; expect_st("prepara", 6);
        tick; expect_st("pump_on", 7);
        for (int c = 1; c <= DS * 10; c++) begin
            noise();
            fim_bomba = (c % 10 == 0);
            if (c == abort_at) begin
                if (by_reset) begin
                    #2 reset = 0;
                    #1 expect_st("async_reset", 0);
                    @(negedge clock) reset = 1;
                    tick; expect_st("after_reset", 0);
                end else begin
                    liga = 1;
                    tick; expect_st("abort", 0);
                end
                liga = 1;
                tick; expect_st("relig", 1);
                return;
            end
            tick; expect_st(c == DS * 10 ? "fim" : "pump", c == DS * 10 ? 8 : 7);
        end
        tick; expect_st("back_idle", 1);
    endtask

    initial begin
        int r;
        #1 reset = 0;
        #11 expect_st("reset", 0);
        @(negedge clock) reset = 1;
        tick; expect_st("post_reset", 0);
        liga = 1;
        tick; expect_st("liga", 1);
        pat = '{1, 1};         run_dose(0, 1, -1, 0);
        pat = '{1, 0, 1, 1};   run_dose(1, 0, -1, 0);
        pat = '{1, -1, -1, 1}; run_dose(0, 1, -1, 0);
        pat = '{1, 1};         run_dose(1, 1, -1, 0);
        pat = '{1, 1};         run_dose(0, 1, 15, 0);
        pat = '{1, 1};         run_dose(1, 0, 5, 1);
        for (int k = 0; k < 14; k++) begin
            r = $urandom_range(1, 3);
            run_dose(r[0], r[1], ($urandom_range(0, 4) == 0) ? $urandom_range(1, DS * 10) : -1, 1'($urandom_range(0, 1)));
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
